// File: rtl/stack_ctrl.sv
// Sequencer for a descending 8-bit stack pointer and its data memory port.
// Optional bounds checking (ovf/unf) is enabled by defining STACK_BOUNDS_CHECK_EN.
module stack_ctrl #(
  parameter logic [7:0] SP_TOP   = 8'hFF,
  parameter logic [7:0] SP_LIMIT = 8'hAF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [2:0] op_code,
  input  logic [7:0] data_in,
  input  logic [7:0] pc_in,
  input  logic [7:0] sp_addr,
  input  logic [7:0] mem_rdata,
  output logic       op_ready,
  output logic       done,
  output logic [1:0] sp_rw,
  output logic       mem_we,
  output logic       mem_re,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic [7:0] data_out,
  output logic       pc_load,
  output logic [7:0] pc_out,
  output logic       ovf,
  output logic       unf
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_INC  = 3'd2,
    S_RD   = 3'd3,
    S_CAP  = 3'd4
  } state_t;

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_LDSP = 3'b101;

  localparam logic [1:0] RW_HOLD = 2'b00;
  localparam logic [1:0] RW_DEC  = 2'b01;
  localparam logic [1:0] RW_INC  = 2'b10;
  localparam logic [1:0] RW_LOAD = 2'b11;

`ifdef STACK_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       ldsp_s;
  logic       refuse_push_s;
  logic       refuse_pop_s;

  logic [1:0] sp_rw_q, sp_rw_d;
  logic       mem_we_q, mem_we_d;
  logic       mem_re_q, mem_re_d;
  logic       acc_q, acc_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       done_q, done_d;
  logic       cap_q, cap_d;
  logic       pc_load_q, pc_load_d;
  logic       op_ready_q, op_ready_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic [7:0] data_q;
  logic [7:0] pc_q;

  // State, latched opcode and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 3'b000;
      sp_rw_q     <= RW_HOLD;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      acc_q       <= 1'b0;
      mem_wdata_q <= 8'h00;
      done_q      <= 1'b0;
      cap_q       <= 1'b0;
      pc_load_q   <= 1'b0;
      op_ready_q  <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      data_q      <= 8'h00;
      pc_q        <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sp_rw_q     <= sp_rw_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      acc_q       <= acc_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      cap_q       <= cap_d;
      pc_load_q   <= pc_load_d;
      op_ready_q  <= op_ready_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      // Popped values arrive on mem_rdata during CAP; keep them afterwards
      if (cap_q) begin
        data_q <= mem_rdata;
      end else begin
        data_q <= data_q;
      end
      if (pc_load_q) begin
        pc_q <= mem_rdata;
      end else begin
        pc_q <= pc_q;
      end
    end
  end

  // Next-state decode; refusals and LDSP complete without leaving IDLE
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    ldsp_s        = 1'b0;
    refuse_push_s = 1'b0;
    refuse_pop_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_d = op_code;
          case (op_code)
            OP_PUSH, OP_CALL: begin
              if (BOUNDS_EN && (sp_addr == SP_LIMIT)) begin
                refuse_push_s = 1'b1;
                state_d       = S_IDLE;
              end else begin
                state_d = S_WR;
              end
            end
            OP_POP, OP_RET: begin
              if (BOUNDS_EN && (sp_addr == SP_TOP)) begin
                refuse_pop_s = 1'b1;
                state_d      = S_IDLE;
              end else begin
                state_d = S_INC;
              end
            end
            OP_LDSP: begin
              ldsp_s  = 1'b1;
              state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR:    state_d = S_IDLE;
      S_INC:   state_d = S_RD;
      S_RD:    state_d = S_CAP;
      S_CAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, registered on the same edge as the state
  always_comb begin
    sp_rw_d     = RW_HOLD;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    acc_d       = 1'b0;
    mem_wdata_d = 8'h00;
    done_d      = 1'b0;
    cap_d       = 1'b0;
    pc_load_d   = 1'b0;
    op_ready_d  = (state_d == S_IDLE);
    ovf_d       = ovf_q | refuse_push_s;
    unf_d       = unf_q | refuse_pop_s;
    case (state_d)
      S_IDLE: begin
        if (ldsp_s) begin
          sp_rw_d = RW_LOAD;
          done_d  = 1'b1;
        end else if (refuse_push_s || refuse_pop_s) begin
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      S_WR: begin
        // Only reachable straight from acceptance, so the inputs are still current
        sp_rw_d  = RW_DEC;
        mem_we_d = 1'b1;
        acc_d    = 1'b1;
        done_d   = 1'b1;
        if (op_code == OP_CALL) begin
          mem_wdata_d = pc_in;
        end else begin
          mem_wdata_d = data_in;
        end
      end
      S_INC: begin
        sp_rw_d = RW_INC;
      end
      S_RD: begin
        mem_re_d = 1'b1;
        acc_d    = 1'b1;
      end
      S_CAP: begin
        done_d = 1'b1;
        if (op_q == OP_RET) begin
          pc_load_d = 1'b1;
        end else begin
          cap_d = 1'b1;
        end
      end
      default: begin
        sp_rw_d = RW_HOLD;
      end
    endcase
  end

  // mem_addr follows sp_addr live so RD sees the freshly incremented pointer
  assign mem_addr  = acc_q ? sp_addr : 8'h00;
  assign op_ready  = op_ready_q;
  assign done      = done_q;
  assign sp_rw     = sp_rw_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_wdata = mem_wdata_q;
  assign data_out  = cap_q ? mem_rdata : data_q;
  assign pc_load   = pc_load_q;
  assign pc_out    = pc_load_q ? mem_rdata : pc_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencer for the 8-bit descending stack-pointer block and the data memory port it addresses.
- Turns single-cycle stack requests from the decoder (PUSH, POP, CALL, RET, LDSP) into timed sequences:
  - the stack pointer's 2-bit `rw` code (00 hold, 01 decrement, 10 increment, 11 load r0);
  - memory read/write strobes.
- Handles the PC hand-off for CALL/RET and flags overflow/underflow against the 80-entry window.

Parameters:
- SP_TOP, 8'hFF, empty value of SP; POP refused when SP equals this.
- SP_LIMIT, 8'hAF, full value of SP; PUSH/CALL refused when SP equals this (FF..B0 gives 80 entries).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  request strobe; sampled only when op_ready=1.
- op_code  in  3  000 NOP, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 LDSP; 11x treated as NOP.
- data_in  in  8  register value for PUSH.
- pc_in  in  8  return address for CALL.
- sp_addr  in  8  current stack pointer, the stack block's `address` output.
- mem_rdata  in  8  memory read data, valid the cycle after mem_re.
- op_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse on completion or refusal.
- sp_rw  out  2  drives the stack block's `rw` input.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_addr  out  8  memory address (sp_addr during stack access).
- mem_wdata  out  8  write data.
- data_out  out  8  popped value, held until the next POP/RET completes.
- pc_load  out  1  one-cycle pulse; pc_out valid.
- pc_out  out  8  return address popped by RET.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.

Behaviour:
- Reset:
  - Reset is synchronous and active-high. While rst=1 at a posedge, the FSM goes to IDLE.
  - All outputs are 0 except op_ready=1. sp_rw=00, so SP is held, not reinitialised; software sets SP with LDSP.
  - Reset mid-sequence abandons the operation with no done pulse. An increment or decrement already clocked into SP is not undone.
- Convention: SP points to the next free slot.
  - PUSH writes at SP, then SP decrements.
  - POP increments SP, then reads at the new SP.
- States: IDLE, WR, INC, RD, CAP.
- IDLE:
  - op_ready=1. On op_valid with PUSH/CALL go to WR; POP/RET go to INC; LDSP drives sp_rw=11 in the next cycle and pulses done; NOP stays.
  - The opcode and write data are latched on acceptance.
- WR (1 cycle):
  - mem_addr=sp_addr, mem_wdata=latched data (data_in for PUSH, pc_in for CALL), mem_we=1, sp_rw=01, done=1.
  - Next state IDLE.
- INC (1 cycle): sp_rw=10. Next state RD.
- RD (1 cycle): mem_addr=sp_addr (already incremented), mem_re=1, sp_rw=00. Next state CAP.
- CAP (1 cycle):
  - Capture mem_rdata into data_out (POP) or pc_out with pc_load=1 (RET); done=1.
  - Next state IDLE.
- Latency from the acceptance edge:
  - PUSH/CALL/LDSP: done in cycle +1.
  - POP/RET: done in cycle +3.
- Throughput: no back-to-back acceptance; op_ready=0 outside IDLE.
- sp_rw is 00 in every state not listed above.
- LDSP is never bounds-checked.
- Simultaneous rst and op_valid: reset wins; the request is dropped.

Optional Feature:
- Macro: STACK_BOUNDS_CHECK_EN.
- Defined:
  - PUSH/CALL accepted with sp_addr==SP_LIMIT sets ovf; POP/RET accepted with sp_addr==SP_TOP sets unf.
  - In both cases there are no mem or sp_rw strobes, done pulses in cycle +1, and the FSM returns to IDLE.
  - ovf/unf clear only on rst.
- Undefined: no check; SP wraps modulo 256; ovf and unf are tied to 0.

Test Plan:
- LDSP with r0=FF, PUSH 8'h3C -> mem_we=1 at mem_addr FF, wdata 3C, sp_rw=01, done at +1; SP becomes FE.
- POP after that -> sp_rw=10 at +1, mem_re at addr FF at +2, data_out=3C and done at +3; SP=FF.
- CALL pc_in=8'h42, then RET -> pc_load pulse with pc_out=42 at RET +3, SP back to FF.
- With STACK_BOUNDS_CHECK_EN:
  - 80 PUSHes from FF end with SP=AF.
  - The 81st sets ovf=1 with no mem_we.
  - POP at SP=FF sets unf=1, no mem_re, done at +1.
- rst asserted during the RD state of a POP -> next cycle IDLE, op_ready=1, no done, data_out=00.
- op_valid held high during a POP -> only one operation accepted; the next is accepted only after return to IDLE.
